// File: rtl/sprite_rom_scheduler_pkg.sv
// Shared types and default geometry for the sprite ROM scheduler.
package sprite_pkg;

    localparam int DEF_SPR_W      = 25;
    localparam int DEF_SPR_H      = 30;
    localparam int DEF_ORG_X      = 13;
    localparam int DEF_ORG_Y      = 15;
    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_IDX_W      = 3;
    localparam int DEF_TRANSP_IDX = 0;
    localparam int DEF_V_ACTIVE   = 480;

    localparam logic [9:0] POS_OFFSCREEN = 10'h3FF;

    typedef enum logic {
        SPR_FIRE  = 1'b0,
        SPR_WATER = 1'b1
    } sprite_id_e;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        COMMIT = 2'd1,
        VBLANK = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sprite_rom_scheduler_hit_calc.sv
// Per-sprite coverage test: anchor position + current pixel -> hit and texel offsets.
// Signed 11-bit math so anchors closer to the edge than the origin offset do not wrap.
module sprite_hit_calc
    import sprite_pkg::*;
#(
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H,
    parameter int ORG_X = DEF_ORG_X,
    parameter int ORG_Y = DEF_ORG_Y
)(
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic               hit,
    output logic signed [10:0] dx,
    output logic signed [10:0] dy
);

    logic signed [10:0] left;
    logic signed [10:0] top;

    // Offsets of the pixel from the sprite's top-left corner and the box test.
    always_comb begin
        left = $signed({1'b0, pos_x}) - $signed(11'(ORG_X));
        top  = $signed({1'b0, pos_y}) - $signed(11'(ORG_Y));
        dx   = $signed({1'b0, DrawX}) - left;
        dy   = $signed({1'b0, DrawY}) - top;
        hit  = (dx >= 11'sd0) && (dx < $signed(11'(SPR_W))) &&
               (dy >= 11'sd0) && (dy < $signed(11'(SPR_H)));
    end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Shares one sync-read sprite ROM between the fireboy and watergirl renderers.
// Positions are double-buffered and committed at vblank entry; 3-cycle pixel pipeline.
module sprite_rom_scheduler
    import sprite_pkg::*;
#(
    parameter int SPR_W      = DEF_SPR_W,
    parameter int SPR_H      = DEF_SPR_H,
    parameter int ORG_X      = DEF_ORG_X,
    parameter int ORG_Y      = DEF_ORG_Y,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int TRANSP_IDX = DEF_TRANSP_IDX,
    parameter int V_ACTIVE   = DEF_V_ACTIVE
)(
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [1:0]        pos_we,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              prio,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_opaque,
    output logic              pix_sprite,
    output logic              frame_start,
    output logic              bbox_overlap,
    output sched_state_e      fsm_state
);

    localparam logic [ADDR_W-1:0] WATER_BASE = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SPR_W);

    sched_state_e       state, state_n;
    logic [9:0]         shadow_x [2];
    logic [9:0]         shadow_y [2];
    logic [9:0]         shadow_nx [2];
    logic [9:0]         shadow_ny [2];
    logic [9:0]         live_x [2];
    logic [9:0]         live_y [2];
    logic [1:0]         hit;
    logic signed [10:0] dx [2];
    logic signed [10:0] dy [2];
    logic               any_hit;
    sprite_id_e         sel;
    logic [10:0]        sel_dx, sel_dy;
    logic [ADDR_W-1:0]  addr_c;
    logic [10:0]        diff_x, diff_y, abs_x, abs_y;
    logic               overlap_c;
    logic               s1_hit, s1_sel, s1_blank;
    logic               s2_hit, s2_sel, s2_blank;

    assign frame_start = (state == COMMIT);
    assign fsm_state   = state;

    // Frame state register; reset parks in VBLANK so nothing starts before the origin.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= VBLANK;
        else          state <= state_n;
    end

    // Next state: commit on the first DrawY == V_ACTIVE, re-arm at pixel (0,0).
    always_comb begin
        state_n = state;
        case (state)
            ACTIVE:  if (DrawY == 10'(V_ACTIVE)) state_n = COMMIT;
            COMMIT:  state_n = VBLANK;
            VBLANK:  if (DrawX == 10'd0 && DrawY == 10'd0) state_n = ACTIVE;
            default: state_n = VBLANK;
        endcase
    end

    // Shadow values after this cycle's writes; also what a commit latches (write bypass).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            shadow_nx[i] = pos_we[i] ? pos_x : shadow_x[i];
            shadow_ny[i] = pos_we[i] ? pos_y : shadow_y[i];
        end
        diff_x    = {1'b0, shadow_nx[0]} - {1'b0, shadow_nx[1]};
        diff_y    = {1'b0, shadow_ny[0]} - {1'b0, shadow_ny[1]};
        abs_x     = diff_x[10] ? (11'd0 - diff_x) : diff_x;
        abs_y     = diff_y[10] ? (11'd0 - diff_y) : diff_y;
        overlap_c = (abs_x < 11'(SPR_W)) && (abs_y < 11'(SPR_H));
    end

    // Shadow/live position registers and the per-frame overlap flag.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                shadow_x[i] <= POS_OFFSCREEN;
                shadow_y[i] <= POS_OFFSCREEN;
                live_x[i]   <= POS_OFFSCREEN;
                live_y[i]   <= POS_OFFSCREEN;
            end
            bbox_overlap <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                shadow_x[i] <= shadow_nx[i];
                shadow_y[i] <= shadow_ny[i];
                if (state == COMMIT) begin
                    live_x[i] <= shadow_nx[i];
                    live_y[i] <= shadow_ny[i];
                end
            end
            if (state == COMMIT) bbox_overlap <= overlap_c;
        end
    end

    sprite_hit_calc #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ORG_X(ORG_X), .ORG_Y(ORG_Y)) u_hit_fire (
        .pos_x(live_x[0]), .pos_y(live_y[0]), .DrawX(DrawX), .DrawY(DrawY),
        .hit(hit[0]), .dx(dx[0]), .dy(dy[0])
    );

    sprite_hit_calc #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ORG_X(ORG_X), .ORG_Y(ORG_Y)) u_hit_water (
        .pos_x(live_x[1]), .pos_y(live_y[1]), .DrawX(DrawX), .DrawY(DrawY),
        .hit(hit[1]), .dx(dx[1]), .dy(dy[1])
    );

    // Arbiter: prio breaks ties; the winner owns the pixel even if its texel is transparent.
    always_comb begin
        any_hit = hit[0] | hit[1];
        sel     = (hit[0] & hit[1]) ? sprite_id_e'(prio) : sprite_id_e'(hit[1]);
        sel_dx  = (sel == SPR_WATER) ? dx[1] : dx[0];
        sel_dy  = (sel == SPR_WATER) ? dy[1] : dy[0];
        addr_c  = ((sel == SPR_WATER) ? WATER_BASE : '0) +
                  ADDR_W'(sel_dy) * ROW_STRIDE + ADDR_W'(sel_dx);
    end

    // Pixel pipeline: address stage, ROM-wait stage, output stage; no stalls.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr   <= '0;
            s1_hit     <= 1'b0;
            s1_sel     <= 1'b0;
            s1_blank   <= 1'b0;
            s2_hit     <= 1'b0;
            s2_sel     <= 1'b0;
            s2_blank   <= 1'b0;
            pix_idx    <= '0;
            pix_opaque <= 1'b0;
            pix_sprite <= 1'b0;
        end else begin
            if (any_hit) rom_addr <= addr_c;
            s1_hit     <= any_hit;
            s1_sel     <= (sel == SPR_WATER);
            s1_blank   <= blank;
            s2_hit     <= s1_hit;
            s2_sel     <= s1_sel;
            s2_blank   <= s1_blank;
            pix_idx    <= s2_hit ? rom_q : '0;
            pix_opaque <= s2_hit && s2_blank && (rom_q != IDX_W'(TRANSP_IDX));
            pix_sprite <= s2_hit && s2_sel;
        end
    end

endmodule
